instr_loader: RTL

//  Writer side of the instruction memory: receives a program image as a byte stream,

---
 rtl/loader_pkg.sv | 20 ++
 rtl/loader_word_pack.sv | 70 +++++++
 rtl/instr_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
//   state_e        : loader FSM states
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   CHK_WIDTH      : width of the running XOR checksum
package loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CHK_WIDTH      = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/loader_word_pack.sv
// Packs a little-endian byte stream into instruction words.
//   clk, rst      : clock, asynchronous active-high reset
//   clear_i       : restart packing at byte 0 (new frame)
//   byte_valid_i  : byte_i is a data byte to pack this cycle
//   byte_i        : stream byte
//   last_byte_o   : the next packed byte completes a word
//   word_valid_o  : 1-cycle pulse, word_o holds a freshly completed word
//   word_o        : last completed word (held until the next one completes)
module loader_word_pack
    import loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_i,
    input  logic                        byte_valid_i,
    input  logic [7:0]                  byte_i,
    output logic                        last_byte_o,
    output logic                        word_valid_o,
    output logic [8*BYTES_PER_WORD-1:0] word_o
);

    localparam int unsigned WordW = 8 * BYTES_PER_WORD;

    logic [1:0]       cnt_q, cnt_d;
    logic [WordW-9:0] shift_q, shift_d;
    logic [WordW-1:0] word_q, word_d;
    logic             valid_q, valid_d;

    // Completed words move into a separate holding register, so byte 0 of the
    // next word can be accepted while the previous word is being written.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (byte_valid_i) begin
            case (cnt_q)
                2'd0:    shift_d[7:0]   = byte_i;
                2'd1:    shift_d[15:8]  = byte_i;
                2'd2:    shift_d[23:16] = byte_i;
                default: begin
                    word_d  = {byte_i, shift_q};
                    valid_d = 1'b1;
                end
            endcase
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign last_byte_o  = (cnt_q == 2'd3);
    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/instr_loader.sv
// Instruction memory loader: receives a framed program image over a byte link,
// writes it into the instruction RAM and holds the CPU until the image is verified.
// Frame: LEN_LO, LEN_HI (word count N), 4*N data bytes (LE), XOR checksum byte.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a load (only from idle, done or error)
//   rx_data/rx_valid/rx_ready : byte stream in, transfer on rx_valid & rx_ready
//   we/waddr/wdata            : instruction RAM write port (word addressed)
//   cpu_hold   : 1 keeps the CPU in reset, released only once the load is good
//   done/error : load complete and verified / checksum or length failure
module instr_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned MaxWords = 2 ** ADDR_WIDTH;

    state_e                 state_q, state_d;
    logic [15:0]            len_q, len_d;
    logic [15:0]            words_q, words_d;
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [CHK_WIDTH-1:0]   chk_q, chk_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   cpu_hold_q, cpu_hold_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic                   accept;
    logic                   start_ok;
    logic                   data_byte;
    logic                   last_byte;
    logic                   word_valid;
    logic [15:0]            len_full;

    assign accept    = rx_valid & rx_ready_q;
    assign start_ok  = start & (state_q inside {StIdle, StDone, StErr});
    assign data_byte = accept & (state_q == StData);
    assign len_full  = {rx_data, len_q[7:0]};

    loader_word_pack u_pack (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_ok),
        .byte_valid_i (data_byte),
        .byte_i       (rx_data),
        .last_byte_o  (last_byte),
        .word_valid_o (word_valid),
        .word_o       (wdata)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        chk_d   = chk_q;
        waddr_d = waddr_q;
        if (word_valid) begin
            waddr_d = waddr_q + 1'b1;
        end
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLenLo;
                    chk_d   = '0;
                    waddr_d = '0;
                    words_d = '0;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = len_full;
                    if (32'(len_full) > MaxWords) begin
                        state_d = StErr;
                    end else if (len_full == 16'd0) begin
                        state_d = StChk;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    chk_d = chk_q ^ rx_data;
                    if (last_byte) begin
                        words_d = words_q + 16'd1;
                        if (words_q == len_q - 16'd1) begin
                            state_d = StChk;
                        end
                    end
                end
            end
            StChk: begin
                if (accept) begin
                    state_d = (rx_data == chk_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase

        // Status outputs are registered copies of the next state.
        rx_ready_d = state_d inside {StLenLo, StLenHi, StData, StChk};
        cpu_hold_d = (state_d != StDone);
        done_d     = (state_d == StDone);
        error_d    = (state_d == StErr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            words_q    <= '0;
            chk_q      <= '0;
            waddr_q    <= '0;
            rx_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            words_q    <= words_d;
            chk_q      <= chk_d;
            waddr_q    <= waddr_d;
            rx_ready_q <= rx_ready_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign we       = word_valid;
    assign waddr    = waddr_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
